// File: rtl/text_cursor_controller_if.sv
// Handshake and plane-write bundle for text_cursor_controller.
//   char_valid/char_data/char_ready : byte stream from the text source
//   clear_req                       : level request for a full-plane clear
//   plane_data/row/col/we/push_up   : character plane write port
//   cursor_row/cursor_col/busy      : controller status
// master = text source / plane side, slave = controller.
interface text_cursor_controller_if #(
  parameter int ROW_BIT_LEN = 4,
  parameter int COL_BIT_LEN = 6,
  parameter int DATA_SIZE   = 8
);
  logic                   char_valid;
  logic [DATA_SIZE-1:0]   char_data;
  logic                   char_ready;
  logic                   clear_req;
  logic [DATA_SIZE-1:0]   plane_data;
  logic [ROW_BIT_LEN-1:0] plane_row;
  logic [COL_BIT_LEN-1:0] plane_col;
  logic                   plane_we;
  logic                   plane_push_up;
  logic [ROW_BIT_LEN-1:0] cursor_row;
  logic [COL_BIT_LEN-1:0] cursor_col;
  logic                   busy;

  modport master (
    output char_valid, char_data, clear_req,
    input  char_ready, plane_data, plane_row, plane_col, plane_we,
           plane_push_up, cursor_row, cursor_col, busy
  );

  modport slave (
    input  char_valid, char_data, clear_req,
    output char_ready, plane_data, plane_row, plane_col, plane_we,
           plane_push_up, cursor_row, cursor_col, busy
  );
endinterface

// File: rtl/text_cursor_controller.sv
// Cursor/sequencing controller for the 15x40 character plane.
// Accepts character codes, writes printables at the cursor, handles CR, LF
// and backspace, scrolls at the bottom line (push_up + wipe of row 14) and
// clears the whole plane on request.
// Ports:
//   clock   : system clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : text_cursor_controller_if.slave (stream in, plane write out)
module text_cursor_controller #(
  parameter int ROW_NUMBER  = 15,
  parameter int COL_NUMBER  = 40,
  parameter int ROW_BIT_LEN = 4,
  parameter int COL_BIT_LEN = 6,
  parameter int DATA_SIZE   = 8
) (
  input  logic                     clock,
  input  logic                     reset_n,
  text_cursor_controller_if.slave  bus
);

  localparam logic [ROW_BIT_LEN-1:0] LAST_ROW = ROW_BIT_LEN'(ROW_NUMBER - 1);
  localparam logic [COL_BIT_LEN-1:0] LAST_COL = COL_BIT_LEN'(COL_NUMBER - 1);
  localparam logic [ROW_BIT_LEN-1:0] ROW_ONE  = ROW_BIT_LEN'(1);
  localparam logic [COL_BIT_LEN-1:0] COL_ONE  = COL_BIT_LEN'(1);
  localparam logic [DATA_SIZE-1:0]   CH_NUL   = '0;
  localparam logic [DATA_SIZE-1:0]   CH_BS    = DATA_SIZE'(8'h08);
  localparam logic [DATA_SIZE-1:0]   CH_LF    = DATA_SIZE'(8'h0A);
  localparam logic [DATA_SIZE-1:0]   CH_CR    = DATA_SIZE'(8'h0D);

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_SCROLL, S_WIPE, S_CLEAR} state_t;

  state_t                 r_state, w_state_nxt;
  logic [ROW_BIT_LEN-1:0] r_cur_row, w_row_nxt;
  logic [COL_BIT_LEN-1:0] r_cur_col, w_col_nxt;
  logic                   r_adv, w_adv_nxt;
  logic [DATA_SIZE-1:0]   r_plane_data, w_pl_data;
  logic [ROW_BIT_LEN-1:0] r_plane_row, w_pl_row;
  logic [COL_BIT_LEN-1:0] r_plane_col, w_pl_col;
  logic                   r_we, w_we;
  logic                   r_push, w_push;
  logic                   r_busy;

  // State and cursor register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_cur_row <= '0;
      r_cur_col <= '0;
      r_adv     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cur_row <= w_row_nxt;
      r_cur_col <= w_col_nxt;
      r_adv     <= w_adv_nxt;
    end
  end

  // Next state and cursor
  always_comb begin
    w_state_nxt = r_state;
    w_row_nxt   = r_cur_row;
    w_col_nxt   = r_cur_col;
    w_adv_nxt   = r_adv;
    case (r_state)
      S_IDLE: begin
        if (bus.clear_req) begin
          w_state_nxt = S_CLEAR;
        end else if (bus.char_valid) begin
          case (bus.char_data)
            CH_NUL: ;
            CH_CR:  w_col_nxt = '0;
            CH_LF: begin
              w_col_nxt = '0;
              if (r_cur_row != LAST_ROW) w_row_nxt = r_cur_row + ROW_ONE;
              else                       w_state_nxt = S_SCROLL;
            end
            CH_BS: begin
              // Backspace moves the cursor now and writes a blank there;
              // the write must not advance it again.
              if (r_cur_col != '0) begin
                w_col_nxt   = r_cur_col - COL_ONE;
                w_adv_nxt   = 1'b0;
                w_state_nxt = S_WRITE;
              end
            end
            default: begin
              w_adv_nxt   = 1'b1;
              w_state_nxt = S_WRITE;
            end
          endcase
        end
      end
      S_WRITE: begin
        w_state_nxt = S_IDLE;
        if (r_adv) begin
          if (r_cur_col != LAST_COL) begin
            w_col_nxt = r_cur_col + COL_ONE;
          end else begin
            w_col_nxt = '0;
            if (r_cur_row != LAST_ROW) w_row_nxt = r_cur_row + ROW_ONE;
            else                       w_state_nxt = S_SCROLL;
          end
        end
      end
      S_SCROLL: w_state_nxt = S_WIPE;
      S_WIPE:   if (r_plane_col == LAST_COL) w_state_nxt = S_IDLE;
      S_CLEAR: begin
        if (r_plane_row == LAST_ROW && r_plane_col == LAST_COL) begin
          w_state_nxt = S_IDLE;
          w_row_nxt   = '0;
          w_col_nxt   = '0;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output decode from the upcoming state; the plane address registers
  // double as the wipe/clear sweep counters.
  always_comb begin
    w_we      = 1'b0;
    w_push    = 1'b0;
    w_pl_row  = r_plane_row;
    w_pl_col  = r_plane_col;
    w_pl_data = r_plane_data;
    case (w_state_nxt)
      S_WRITE: begin
        // WRITE is only entered from IDLE: printable keeps the cursor
        // column, backspace uses the already-decremented one.
        w_we      = 1'b1;
        w_pl_row  = r_cur_row;
        w_pl_col  = w_col_nxt;
        w_pl_data = (bus.char_data == CH_BS) ? '0 : bus.char_data;
      end
      S_SCROLL: w_push = 1'b1;
      S_WIPE: begin
        w_we      = 1'b1;
        w_pl_row  = LAST_ROW;
        w_pl_data = '0;
        w_pl_col  = (r_state == S_WIPE) ? r_plane_col + COL_ONE : '0;
      end
      S_CLEAR: begin
        w_we      = 1'b1;
        w_pl_data = '0;
        if (r_state != S_CLEAR) begin
          w_pl_row = '0;
          w_pl_col = '0;
        end else if (r_plane_col == LAST_COL) begin
          w_pl_row = r_plane_row + ROW_ONE;
          w_pl_col = '0;
        end else begin
          w_pl_col = r_plane_col + COL_ONE;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_we         <= 1'b0;
      r_push       <= 1'b0;
      r_busy       <= 1'b0;
      r_plane_row  <= '0;
      r_plane_col  <= '0;
      r_plane_data <= '0;
    end else begin
      r_we         <= w_we;
      r_push       <= w_push;
      r_busy       <= (w_state_nxt != S_IDLE);
      r_plane_row  <= w_pl_row;
      r_plane_col  <= w_pl_col;
      r_plane_data <= w_pl_data;
    end
  end

  // Ready is decoded from the state register; clear_req masks it so a
  // pending clear always wins over a presented code.
  assign bus.char_ready    = (r_state == S_IDLE) && !bus.clear_req;
  assign bus.plane_data    = r_plane_data;
  assign bus.plane_row     = r_plane_row;
  assign bus.plane_col     = r_plane_col;
  assign bus.plane_we      = r_we;
  assign bus.plane_push_up = r_push;
  assign bus.cursor_row    = r_cur_row;
  assign bus.cursor_col    = r_cur_col;
  assign bus.busy          = r_busy;

endmodule
